mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_pkg.sv | 25 ++
 rtl/mul_div_unit.sv | 169 ++++++++++++++++
 tb/tb_mul_div_unit.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/mul_div_pkg.sv
// mul_div_pkg: shared constants and encodings for mul_div_unit.
//   DefaultDataWidth : default operand/result width
//   NumIter          : radix-2 iterations per multiply/divide
//   op_e             : i_Op encodings (MUL, MULH, DIV, REM)
//   state_e          : FSM state encodings (IDLE, CALC, FIX, DONE)
package mul_div_pkg;

  localparam int unsigned DefaultDataWidth = 32;
  localparam int unsigned NumIter          = 32;

  typedef enum logic [1:0] {
    OpMul  = 2'b00,
    OpMulh = 2'b01,
    OpDiv  = 2'b10,
    OpRem  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StCalc = 2'b01,
    StFix  = 2'b10,
    StDone = 2'b11
  } state_e;

endpackage

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative multiply/divide unit for a register-file writeback port.
// Shift-add multiply (full 2*DATA_WIDTH product) and restoring divide, one bit per cycle.
// Optional feature macro: MUL_DIV_SIGNED_EN (honour i_Signed as two's complement).
// Ports:
//   i_CLK, i_RST       clock, synchronous active-high reset
//   i_Start            request, accepted only when idle
//   i_Op               00 MUL, 01 MULH, 10 DIV, 11 REM
//   i_Signed           signed operands (only with MUL_DIV_SIGNED_EN)
//   i_Operand1/2       multiplicand/dividend, multiplier/divisor
//   i_Rd_Addr          destination register, captured at accept
//   o_Busy             high whenever not idle
//   o_Done/o_RegWrite  one-cycle result-valid / register write enable
//   o_Result           result word, held until the next result or reset
//   o_Write_Reg_Addr   destination register for o_Result
module mul_div_unit
  import mul_div_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefaultDataWidth
) (
  input  logic                  i_CLK,
  input  logic                  i_RST,
  input  logic                  i_Start,
  input  logic [1:0]            i_Op,
  input  logic                  i_Signed,
  input  logic [DATA_WIDTH-1:0] i_Operand1,
  input  logic [DATA_WIDTH-1:0] i_Operand2,
  input  logic [4:0]            i_Rd_Addr,
  output logic                  o_Busy,
  output logic                  o_Done,
  output logic [DATA_WIDTH-1:0] o_Result,
  output logic                  o_RegWrite,
  output logic [4:0]            o_Write_Reg_Addr
);

  localparam int unsigned W = DATA_WIDTH;

  state_e         state_q;
  op_e            op_q;
  logic [5:0]     cnt_q;
  logic [W-1:0]   hi_q, lo_q, opb_q;
  logic           neg_q, dz_q;
  logic [4:0]     rd_q;

  logic           sgn_en;
`ifdef MUL_DIV_SIGNED_EN
  assign sgn_en = i_Signed;
`else
  logic unused_signed;
  assign unused_signed = i_Signed;
  assign sgn_en        = 1'b0;
`endif

  // Operands are reduced to magnitudes at accept; the sign is restored in FIX.
  logic         a_neg, b_neg, div_zero, neg_d;
  logic [W-1:0] a_mag, b_mag;
  op_e          op_in;

  always_comb begin
    op_in    = op_e'(i_Op);
    a_neg    = sgn_en & i_Operand1[W-1];
    b_neg    = sgn_en & i_Operand2[W-1];
    a_mag    = a_neg ? -i_Operand1 : i_Operand1;
    b_mag    = b_neg ? -i_Operand2 : i_Operand2;
    div_zero = i_Op[1] && (i_Operand2 == '0);
    // Remainder takes the dividend's sign, everything else the product of signs.
    neg_d    = (op_in == OpRem) ? a_neg : (a_neg ^ b_neg);
  end

  // One radix-2 step. MUL: hi:lo is the product shifting right, opb the multiplicand.
  // DIV: hi is the partial remainder, lo shifts dividend bits out and quotient bits in.
  logic [W:0]   mul_sum, div_shift;
  logic         div_ge;
  logic [W-1:0] hi_step, lo_step;

  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
    div_shift = {hi_q, lo_q[W-1]};
    div_ge    = div_shift >= {1'b0, opb_q};
    hi_step   = '0;
    lo_step   = '0;
    if (op_q[1]) begin
      hi_step = div_ge ? W'(div_shift - {1'b0, opb_q}) : div_shift[W-1:0];
      lo_step = {lo_q[W-2:0], div_ge};
    end else begin
      hi_step = mul_sum[W:1];
      lo_step = {mul_sum[0], lo_q[W-1:1]};
    end
  end

  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   result_fix;

  always_comb begin
    prod_fix   = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    result_fix = '0;
    case (op_q)
      OpMul:  result_fix = prod_fix[W-1:0];
      OpMulh: result_fix = prod_fix[2*W-1:W];
      OpDiv:  result_fix = dz_q ? '1 : (neg_q ? -lo_q : lo_q);
      OpRem:  result_fix = dz_q ? lo_q : (neg_q ? -hi_q : hi_q);
      default: result_fix = '0;
    endcase
  end

  assign o_RegWrite = o_Done;

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q          <= StIdle;
      op_q             <= OpMul;
      cnt_q            <= '0;
      hi_q             <= '0;
      lo_q             <= '0;
      opb_q            <= '0;
      neg_q            <= 1'b0;
      dz_q             <= 1'b0;
      rd_q             <= '0;
      o_Busy           <= 1'b0;
      o_Done           <= 1'b0;
      o_Result         <= '0;
      o_Write_Reg_Addr <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          o_Done <= 1'b0;
          if (i_Start) begin
            op_q   <= op_in;
            rd_q   <= i_Rd_Addr;
            neg_q  <= neg_d;
            dz_q   <= div_zero;
            hi_q   <= '0;
            o_Busy <= 1'b1;
            if (div_zero) begin
              // Raw dividend kept so REM-by-zero returns it unchanged.
              lo_q    <= i_Operand1;
              opb_q   <= '0;
              cnt_q   <= '0;
              state_q <= StFix;
            end else begin
              lo_q    <= i_Op[1] ? a_mag : b_mag;
              opb_q   <= i_Op[1] ? b_mag : a_mag;
              cnt_q   <= 6'(NumIter);
              state_q <= StCalc;
            end
          end
        end
        StCalc: begin
          hi_q  <= hi_step;
          lo_q  <= lo_step;
          cnt_q <= cnt_q - 6'd1;
          if (cnt_q == 6'd1) state_q <= StFix;
        end
        StFix: begin
          o_Result         <= result_fix;
          o_Write_Reg_Addr <= rd_q;
          o_Done           <= 1'b1;
          state_q          <= StDone;
        end
        StDone: begin
          o_Done  <= 1'b0;
          o_Busy  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench for mul_div_unit. Vectors for the signed feature are selected by
// MUL_DIV_SIGNED_EN so the same bench covers both builds.
module tb_mul_div_unit;

  logic        i_CLK = 1'b0;
  logic        i_RST;
  logic        i_Start;
  logic [1:0]  i_Op;
  logic        i_Signed;
  logic [31:0] i_Operand1, i_Operand2;
  logic [4:0]  i_Rd_Addr;
  logic        o_Busy, o_Done, o_RegWrite;
  logic [31:0] o_Result;
  logic [4:0]  o_Write_Reg_Addr;

  int n_checks = 0;
  int n_fail   = 0;

  mul_div_unit #(.DATA_WIDTH(32)) u_dut (
    .i_CLK            (i_CLK),
    .i_RST            (i_RST),
    .i_Start          (i_Start),
    .i_Op             (i_Op),
    .i_Signed         (i_Signed),
    .i_Operand1       (i_Operand1),
    .i_Operand2       (i_Operand2),
    .i_Rd_Addr        (i_Rd_Addr),
    .o_Busy           (o_Busy),
    .o_Done           (o_Done),
    .o_Result         (o_Result),
    .o_RegWrite       (o_RegWrite),
    .o_Write_Reg_Addr (o_Write_Reg_Addr)
  );

  always #5 i_CLK = ~i_CLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge with the DUT idle; accept happens on the next posedge.
  task automatic run_op(input string tag, input logic [1:0] op, input logic sgn,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp, input int exp_lat);
    int lat;
    bit seen;
    i_Start = 1'b1; i_Op = op; i_Signed = sgn;
    i_Operand1 = a; i_Operand2 = b; i_Rd_Addr = rd;
    @(posedge i_CLK); #1;
    // Scramble inputs after accept: result must not change.
    i_Start = 1'b0; i_Op = ~op; i_Operand1 = ~a; i_Operand2 = b ^ 32'h5a5a_5a5a;
    i_Rd_Addr = ~rd;
    lat = 0; seen = 0;
    while (!seen && lat < 40) begin
      @(posedge i_CLK); lat++;
      @(negedge i_CLK);
      if (o_Done) seen = 1;
    end
    check_eq({tag, " latency"}, lat, exp_lat);
    check_eq({tag, " result"}, o_Result, exp);
    check_eq({tag, " rd"}, {27'd0, o_Write_Reg_Addr}, {27'd0, rd});
    check_eq({tag, " regwrite"}, {31'd0, o_RegWrite}, 32'd1);
    @(posedge i_CLK); @(negedge i_CLK);
    check_eq({tag, " done pulse"}, {31'd0, o_Done}, 32'd0);
    check_eq({tag, " hold"}, o_Result, exp);
    @(posedge i_CLK); @(negedge i_CLK);
    check_eq({tag, " idle"}, {31'd0, o_Busy}, 32'd0);
  endtask

  initial begin
    int pulses;
    int k;
    int done_edge[2];
    logic [31:0] done_res[2];

    i_RST = 1'b1; i_Start = 1'b0; i_Op = 2'b00; i_Signed = 1'b0;
    i_Operand1 = '0; i_Operand2 = '0; i_Rd_Addr = '0;
    repeat (3) @(negedge i_CLK);
    check_eq("reset busy", {31'd0, o_Busy}, 32'd0);
    check_eq("reset done", {31'd0, o_Done}, 32'd0);
    check_eq("reset regwrite", {31'd0, o_RegWrite}, 32'd0);
    check_eq("reset result", o_Result, 32'd0);
    check_eq("reset addr", {27'd0, o_Write_Reg_Addr}, 32'd0);
    i_RST = 1'b0;
    @(negedge i_CLK);

    run_op("mul 7x6", 2'b00, 1'b0, 32'd7, 32'd6, 5'd5, 32'd42, 33);
    run_op("mulh max", 2'b01, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFE, 33);
    run_op("mul max", 2'b00, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'h0000_0001, 33);
    run_op("div 100/7", 2'b10, 1'b0, 32'd100, 32'd7, 5'd8, 32'd14, 33);
    run_op("rem 100/7", 2'b11, 1'b0, 32'd100, 32'd7, 5'd9, 32'd2, 33);
    run_op("div 5/0", 2'b10, 1'b0, 32'd5, 32'd0, 5'd10, 32'hFFFF_FFFF, 1);
    run_op("rem 5/0", 2'b11, 1'b0, 32'd5, 32'd0, 5'd11, 32'd5, 1);
    run_op("div big/16", 2'b10, 1'b0, 32'hFFFF_FFFF, 32'h10, 5'd12, 32'h0FFF_FFFF, 33);
    run_op("rem big/16", 2'b11, 1'b0, 32'hFFFF_FFFF, 32'h10, 5'd13, 32'h0000_000F, 33);
`ifdef MUL_DIV_SIGNED_EN
    run_op("sdiv -7/2", 2'b10, 1'b1, 32'hFFFF_FFF9, 32'd2, 5'd14, 32'hFFFF_FFFD, 33);
    run_op("srem -7/2", 2'b11, 1'b1, 32'hFFFF_FFF9, 32'd2, 5'd15, 32'hFFFF_FFFF, 33);
    run_op("sdiv ovf", 2'b10, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000, 33);
    run_op("srem ovf", 2'b11, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h0, 33);
    run_op("smulh -2x3", 2'b01, 1'b1, 32'hFFFF_FFFE, 32'd3, 5'd18, 32'hFFFF_FFFF, 33);
    run_op("smul -2x3", 2'b00, 1'b1, 32'hFFFF_FFFE, 32'd3, 5'd19, 32'hFFFF_FFFA, 33);
`else
    run_op("udiv sgn", 2'b10, 1'b1, 32'hFFFF_FFF9, 32'd2, 5'd14, 32'h7FFF_FFFC, 33);
    run_op("umulh sgn", 2'b01, 1'b1, 32'hFFFF_FFFE, 32'd3, 5'd18, 32'h0000_0002, 33);
`endif

    // Abort mid-CALC: start ignored at edge 10, reset at edge 15.
    i_Start = 1'b1; i_Op = 2'b00; i_Signed = 1'b0;
    i_Operand1 = 32'h1234; i_Operand2 = 32'h5678; i_Rd_Addr = 5'd20;
    @(posedge i_CLK); #1;
    i_Start = 1'b0;
    for (int e = 1; e <= 15; e++) begin
      i_Start = (e == 10);
      if (e == 10) begin
        i_Op = 2'b10; i_Operand1 = 32'd9; i_Operand2 = 32'd0; i_Rd_Addr = 5'd21;
      end
      i_RST = (e == 15);
      @(posedge i_CLK); #1;
      if (e == 14) check_eq("abort busy", {31'd0, o_Busy}, 32'd1);
    end
    i_RST = 1'b0; i_Start = 1'b0;
    @(negedge i_CLK);
    check_eq("abort busy off", {31'd0, o_Busy}, 32'd0);
    check_eq("abort done", {31'd0, o_Done}, 32'd0);
    check_eq("abort result", o_Result, 32'd0);
    check_eq("abort addr", {27'd0, o_Write_Reg_Addr}, 32'd0);
    pulses = 0;
    repeat (40) begin
      @(negedge i_CLK);
      if (o_Done) pulses++;
    end
    check_eq("abort no done", pulses, 0);

    // Reset wins over a simultaneous start.
    i_RST = 1'b1; i_Start = 1'b1; i_Operand1 = 32'd3; i_Operand2 = 32'd4;
    @(posedge i_CLK); @(negedge i_CLK);
    check_eq("rst prio busy", {31'd0, o_Busy}, 32'd0);
    i_RST = 1'b0; i_Start = 1'b0;
    @(negedge i_CLK);
    run_op("mul 3x4", 2'b00, 1'b0, 32'd3, 32'd4, 5'd1, 32'd12, 33);

    // Back-to-back with i_Start held high: accepts at edges 0 and 35.
    i_Start = 1'b1; i_Op = 2'b00; i_Operand1 = 32'd9; i_Operand2 = 32'd9; i_Rd_Addr = 5'd3;
    @(posedge i_CLK); #1;
    i_Op = 2'b10; i_Operand1 = 32'd100; i_Operand2 = 32'd7; i_Rd_Addr = 5'd4;
    k = 0; done_edge[0] = 0; done_edge[1] = 0; done_res[0] = '0; done_res[1] = '0;
    for (int e = 1; e <= 69; e++) begin
      @(posedge i_CLK); @(negedge i_CLK);
      if (o_Done) begin
        if (k < 2) begin
          done_edge[k] = e;
          done_res[k]  = o_Result;
        end
        k++;
      end
      if (e == 34) check_eq("b2b idle gap", {31'd0, o_Busy}, 32'd0);
      if (e == 35) check_eq("b2b reaccept", {31'd0, o_Busy}, 32'd1);
      if (e == 69) i_Start = 1'b0;
    end
    check_eq("b2b pulses", k, 2);
    check_eq("b2b edge0", done_edge[0], 33);
    check_eq("b2b res0", done_res[0], 32'd81);
    check_eq("b2b edge1", done_edge[1], 68);
    check_eq("b2b res1", done_res[1], 32'd14);
    @(posedge i_CLK); @(negedge i_CLK);
    check_eq("b2b final idle", {31'd0, o_Busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
